// File: rtl/occ_pkg.sv
// Shared definitions for the doorway occupancy counter: FSM state encoding and
// sensor-pair codes, with the pair ordered {outer beam a, inner beam b}.
package occ_pkg;

  typedef enum logic [2:0] {
    WAIT_CLR = 3'd0,
    IDLE     = 3'd1,
    EN1      = 3'd2,
    EN2      = 3'd3,
    EN3      = 3'd4,
    EX1      = 3'd5,
    EX2      = 3'd6,
    EX3      = 3'd7
  } occ_state_t;

  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_AB   = 2'b11;

  function automatic logic [1:0] sensor_pair(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-for-DEBOUNCE_CYCLES filter.
// The output reaches the FSM 2 + DEBOUNCE_CYCLES clock edges after din settles.
module sensor_debounce
  import occ_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          held;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      held       <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != held) begin
        if (stable_cnt == LAST) begin
          held       <= sync2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  // The new level is forwarded during its final qualifying cycle, so the FSM
  // samples it on the same edge that commits it to held.
  assign dout = (sync2 != held && stable_cnt == LAST) ? sync2 : held;

endmodule

// File: rtl/occupancy_counter.sv
// Direction-aware doorway occupancy counter with saturating count and full/empty flags.
// Define OCC_DEBOUNCE_EN to insert synchronizer + debounce filters on both sensors.
module occupancy_counter
  import occ_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int MAX_COUNT       = 200,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sens_a,
  input  logic             sens_b,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             sat_err,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  if (MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_config
    $error("occupancy_counter: illegal parameter combination");
  end

  logic a_f;
  logic b_f;

`ifdef OCC_DEBOUNCE_EN
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .din   (sens_a),
    .dout  (a_f)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .din   (sens_b),
    .dout  (b_f)
  );
`else
  assign a_f = sens_a;
  assign b_f = sens_b;
`endif

  occ_state_t state;
  occ_state_t state_next;
  logic [1:0] pair;
  logic       entry_done;
  logic       exit_done;
  logic       illegal;

  assign pair = sensor_pair(a_f, b_f);

  always_comb begin
    state_next = state;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      WAIT_CLR: if (pair == S_NONE) state_next = IDLE;
      IDLE: begin
        unique case (pair)
          S_A:     state_next = EN1;
          S_B:     state_next = EX1;
          S_AB:    begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = IDLE;
        endcase
      end
      EN1: begin
        unique case (pair)
          S_AB:    state_next = EN2;
          S_NONE:  state_next = IDLE;
          S_B:     begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = EN1;
        endcase
      end
      EN2: begin
        unique case (pair)
          S_B:     state_next = EN3;
          S_A:     state_next = EN1;
          S_NONE:  begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = EN2;
        endcase
      end
      EN3: begin
        unique case (pair)
          S_AB:    state_next = EN2;
          S_NONE:  begin state_next = IDLE; entry_done = 1'b1; end
          S_A:     begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = EN3;
        endcase
      end
      EX1: begin
        unique case (pair)
          S_AB:    state_next = EX2;
          S_NONE:  state_next = IDLE;
          S_A:     begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = EX1;
        endcase
      end
      EX2: begin
        unique case (pair)
          S_A:     state_next = EX3;
          S_B:     state_next = EX1;
          S_NONE:  begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = EX2;
        endcase
      end
      EX3: begin
        unique case (pair)
          S_AB:    state_next = EX2;
          S_NONE:  begin state_next = IDLE; exit_done = 1'b1; end
          S_B:     begin state_next = WAIT_CLR; illegal = 1'b1; end
          default: state_next = EX3;
        endcase
      end
      default: state_next = WAIT_CLR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_CLR;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      sat_err     <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_next;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      sat_err     <= 1'b0;
      seq_err     <= illegal;
      if (entry_done) begin
        if (count < MAX_C) begin
          count       <= count + 1'b1;
          full        <= (count + 1'b1 == MAX_C);
          empty       <= 1'b0;
          entry_pulse <= 1'b1;
        end else begin
          sat_err <= 1'b1;
        end
      end else if (exit_done) begin
        if (count != '0) begin
          count      <= count - 1'b1;
          full       <= 1'b0;
          empty      <= (count == WIDTH'(1));
          exit_pulse <= 1'b1;
        end else begin
          sat_err <= 1'b1;
        end
      end
    end
  end

endmodule
